// File: rtl/uart_program_loader.sv
// uart_program_loader
// Boot-time loader: receives an 8N1 UART byte stream on io_rx, assembles
// little-endian 32-bit words and writes them to consecutive word addresses
// of program memory. The image starts with a 4-byte little-endian word
// count N. load_active holds the core off until a complete image is written.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the N data words. It must equal the
//   XOR of all 4N data bytes; the length bytes are not included. A mismatch
//   goes to ERROR and load_done is not pulsed.
module uart_program_loader #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int MEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  output logic        prog_we,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_wdata,
  output logic        load_active,
  output logic        load_done,
  output logic        load_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [31:0]   MEM_LIMIT = 32'(MEM_WORDS);

  // Byte receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Loader states. The completion state differs between builds: without a
  // checksum the last write is followed by a one-cycle FINISH so that
  // load_done trails the final prog_we by exactly one cycle.
  localparam logic [2:0] WAIT_LEN  = 3'd0;
  localparam logic [2:0] WAIT_DATA = 3'd1;
  localparam logic [2:0] DONE      = 3'd2;
  localparam logic [2:0] ERROR     = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] WAIT_CSUM = 3'd5;
`else
  localparam logic [2:0] FINISH    = 3'd4;
`endif

  // Receiver state
  logic          rx_s1_r;
  logic          rx_s2_r;
  logic          rx_prev_r;
  logic [1:0]    rx_state_r;
  logic [CW-1:0] bit_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    rx_shift_r;

  // Receiver event pulses
  logic          bit_tick_s;
  logic          start_s;
  logic          byte_valid_s;
  logic          frame_err_s;

  // Loader state
  logic [2:0]    ld_state_r;
  logic [1:0]    byte_cnt_r;
  logic [31:0]   word_r;
  logic [31:0]   len_r;
  logic [31:0]   idx_r;
  logic [31:0]   word_next_s;
  logic [31:0]   idx_next_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum_r;
`endif

  logic          prog_we_r;
  logic [31:0]   prog_addr_r;
  logic [31:0]   prog_wdata_r;
  logic          load_active_r;
  logic          load_done_r;
  logic          load_error_r;

  assign prog_we     = prog_we_r;
  assign prog_addr   = prog_addr_r;
  assign prog_wdata  = prog_wdata_r;
  assign load_active = load_active_r;
  assign load_done   = load_done_r;
  assign load_error  = load_error_r;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1_r   <= 1'b1;
      rx_s2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_s1_r   <= io_rx;
      rx_s2_r   <= rx_s1_r;
      rx_prev_r <= rx_s2_r;
    end
  end

  // Receiver event decode: start edge, good byte, framing error
  always_comb begin
    bit_tick_s   = (bit_cnt_r == BIT_LAST);
    start_s      = 1'b0;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    if ((rx_state_r == RX_IDLE) && rx_prev_r && !rx_s2_r) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    if ((rx_state_r == RX_STOP) && bit_tick_s) begin
      byte_valid_s = rx_s2_r;
      frame_err_s  = !rx_s2_r;
    end else begin
      byte_valid_s = 1'b0;
      frame_err_s  = 1'b0;
    end
  end

  // Byte receiver FSM: half-bit start check, then centre sampling
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_r <= RX_IDLE;
      bit_cnt_r  <= '0;
      bit_idx_r  <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      case (rx_state_r)
        RX_IDLE: begin
          bit_cnt_r <= '0;
          bit_idx_r <= 3'd0;
          if (start_s) begin
            rx_state_r <= RX_START;
          end else begin
            rx_state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (bit_cnt_r == HALF_LAST) begin
            bit_cnt_r <= '0;
            if (rx_s2_r) begin
              rx_state_r <= RX_IDLE;   // glitch, not a real start bit
            end else begin
              rx_state_r <= RX_DATA;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_tick_s) begin
            bit_cnt_r  <= '0;
            rx_shift_r <= {rx_s2_r, rx_shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              bit_idx_r  <= 3'd0;
              rx_state_r <= RX_STOP;
            end else begin
              bit_idx_r  <= bit_idx_r + 3'd1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_tick_s) begin
            bit_cnt_r  <= '0;
            rx_state_r <= RX_IDLE;
          end else begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          bit_cnt_r  <= '0;
          bit_idx_r  <= 3'd0;
        end
      endcase
    end
  end

  // Next assembled word (little-endian) and next word index
  always_comb begin
    word_next_s = {rx_shift_r, word_r[31:8]};
    idx_next_s  = idx_r + 32'd1;
  end

  // Loader FSM: length header, data words, completion and error handling
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ld_state_r    <= WAIT_LEN;
      byte_cnt_r    <= 2'd0;
      word_r        <= 32'h0;
      len_r         <= 32'h0;
      idx_r         <= 32'h0;
`ifdef LOADER_CHECKSUM_EN
      csum_r        <= 8'h00;
`endif
      prog_we_r     <= 1'b0;
      prog_addr_r   <= 32'h0;
      prog_wdata_r  <= 32'h0;
      load_active_r <= 1'b1;
      load_done_r   <= 1'b0;
      load_error_r  <= 1'b0;
    end else begin
      prog_we_r   <= 1'b0;
      load_done_r <= 1'b0;
      case (ld_state_r)
        WAIT_LEN: begin
          if (frame_err_s) begin
            ld_state_r   <= ERROR;
            load_error_r <= 1'b1;
          end else if (byte_valid_s) begin
            word_r     <= word_next_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              if (word_next_s == 32'h0) begin
                ld_state_r    <= DONE;
                load_done_r   <= 1'b1;
                load_active_r <= 1'b0;
                load_error_r  <= 1'b0;
              end else if (word_next_s > MEM_LIMIT) begin
                ld_state_r   <= ERROR;
                load_error_r <= 1'b1;
              end else begin
                ld_state_r <= WAIT_DATA;
                len_r      <= word_next_s;
                idx_r      <= 32'h0;
`ifdef LOADER_CHECKSUM_EN
                csum_r     <= 8'h00;
`endif
              end
            end else begin
              ld_state_r <= WAIT_LEN;
            end
          end else begin
            ld_state_r <= WAIT_LEN;
          end
        end
        WAIT_DATA: begin
          if (frame_err_s) begin
            ld_state_r   <= ERROR;
            load_error_r <= 1'b1;
          end else if (byte_valid_s) begin
            word_r     <= word_next_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_r     <= csum_r ^ rx_shift_r;
`endif
            if (byte_cnt_r == 2'd3) begin
              prog_we_r    <= 1'b1;
              prog_wdata_r <= word_next_s;
              prog_addr_r  <= {idx_r[29:0], 2'b00};
              idx_r        <= idx_next_s;
              if (idx_next_s == len_r) begin
`ifdef LOADER_CHECKSUM_EN
                ld_state_r <= WAIT_CSUM;
`else
                ld_state_r <= FINISH;
`endif
              end else begin
                ld_state_r <= WAIT_DATA;
              end
            end else begin
              ld_state_r <= WAIT_DATA;
            end
          end else begin
            ld_state_r <= WAIT_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        WAIT_CSUM: begin
          if (frame_err_s) begin
            ld_state_r   <= ERROR;
            load_error_r <= 1'b1;
          end else if (byte_valid_s) begin
            if (rx_shift_r == csum_r) begin
              ld_state_r    <= DONE;
              load_done_r   <= 1'b1;
              load_active_r <= 1'b0;
              load_error_r  <= 1'b0;
            end else begin
              ld_state_r   <= ERROR;
              load_error_r <= 1'b1;
            end
          end else begin
            ld_state_r <= WAIT_CSUM;
          end
        end
`else
        FINISH: begin
          ld_state_r    <= DONE;
          load_done_r   <= 1'b1;
          load_active_r <= 1'b0;
          load_error_r  <= 1'b0;
        end
`endif
        DONE: begin
          if (start_s) begin
            ld_state_r    <= WAIT_LEN;
            load_active_r <= 1'b1;
            load_error_r  <= 1'b0;
            byte_cnt_r    <= 2'd0;
            idx_r         <= 32'h0;
            word_r        <= 32'h0;
          end else begin
            ld_state_r <= DONE;
          end
        end
        ERROR: begin
          // load_error stays set until a later image completes
          load_active_r <= 1'b1;
          if (start_s) begin
            ld_state_r <= WAIT_LEN;
            byte_cnt_r <= 2'd0;
            idx_r      <= 32'h0;
            word_r     <= 32'h0;
          end else begin
            ld_state_r <= ERROR;
          end
        end
        default: begin
          ld_state_r    <= WAIT_LEN;
          byte_cnt_r    <= 2'd0;
          idx_r         <= 32'h0;
          load_active_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed testbench for uart_program_loader (10 clocks per bit, 16 words).
// Optional checksum scenarios build when LOADER_CHECKSUM_EN is defined.
module tb_uart_program_loader;

  logic        clk;
  logic        reset_n;
  logic        io_rx;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        load_active;
  logic        load_done;
  logic        load_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int we_cyc = 0;
  int done_cyc = 0;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  uart_program_loader #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .MEM_WORDS  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .io_rx      (io_rx),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .load_active(load_active),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Monitor write strobes and completion pulses between clock edges
  always @(negedge clk) begin
    if (reset_n && prog_we) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = prog_addr;
        wr_data[wr_cnt] = prog_wdata;
      end
      wr_cnt++;
      we_cyc = cyc;
    end
    if (reset_n && load_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_active_low", {31'h0, load_active}, 32'h0);
    end
  end

  task automatic idle_bits(input int n);
    io_rx = 1'b1;
    repeat (n * 10) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    io_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (10) @(negedge clk);
    end
    io_rx = stop_ok;
    repeat (9) @(negedge clk);
    io_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
    end
  endtask

  task automatic clear_log;
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    io_rx   = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_we",     {31'h0, prog_we},     32'h0);
    check("rst_addr",   prog_addr,            32'h0);
    check("rst_wdata",  prog_wdata,           32'h0);
    check("rst_active", {31'h0, load_active}, 32'h1);
    check("rst_done",   {31'h0, load_done},   32'h0);
    check("rst_error",  {31'h0, load_error},  32'h0);

    // Short low glitch must not start a byte
    clear_log();
    io_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);
    check("glitch_writes", wr_cnt, 32'd0);
    check("glitch_active", {31'h0, load_active}, 32'h1);
    check("glitch_error",  {31'h0, load_error},  32'h0);

    // N=2 image; a miscounted glitch byte would misalign this image
    clear_log();
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h31, 1'b1);
`endif
    idle_bits(2);
    check("n2_writes", wr_cnt, 32'd2);
    check("n2_addr0",  wr_addr[0], 32'h0);
    check("n2_data0",  wr_data[0], 32'h0000_0013);
    check("n2_addr1",  wr_addr[1], 32'h4);
    check("n2_data1",  wr_data[1], 32'hDEAD_BEEF);
    check("n2_done",   done_cnt, 32'd1);
    check("n2_active", {31'h0, load_active}, 32'h0);
    check("n2_error",  {31'h0, load_error},  32'h0);
`ifndef LOADER_CHECKSUM_EN
    check("n2_done_gap", done_cyc - we_cyc, 32'd1);
`endif

    // N=0 image: completes with no writes
    clear_log();
    send_word(32'd0);
    idle_bits(2);
    check("n0_writes", wr_cnt, 32'd0);
    check("n0_done",   done_cnt, 32'd1);
    check("n0_active", {31'h0, load_active}, 32'h0);

    // N=17 exceeds capacity
    clear_log();
    send_word(32'd17);
    idle_bits(2);
    check("n17_error",  {31'h0, load_error},  32'h1);
    check("n17_active", {31'h0, load_active}, 32'h1);
    check("n17_writes", wr_cnt, 32'd0);
    check("n17_done",   done_cnt, 32'd0);

    // Valid N=1 image recovers from ERROR
    clear_log();
    send_word(32'd1);
    send_word(32'h1234_5678);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h08, 1'b1);
`endif
    idle_bits(2);
    check("rec_error",  {31'h0, load_error},  32'h0);
    check("rec_writes", wr_cnt, 32'd1);
    check("rec_addr",   wr_addr[0], 32'h0);
    check("rec_data",   wr_data[0], 32'h1234_5678);
    check("rec_done",   done_cnt, 32'd1);
    check("rec_active", {31'h0, load_active}, 32'h0);

    // Bad stop bit on the 3rd data byte
    clear_log();
    send_word(32'd2);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    idle_bits(2);
    check("ferr_error",  {31'h0, load_error},  32'h1);
    check("ferr_active", {31'h0, load_active}, 32'h1);
    check("ferr_writes", wr_cnt, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum
    clear_log();
    send_word(32'd1);
    send_word(32'h0102_0304);
    send_byte(8'h04, 1'b1);
    idle_bits(2);
    check("csum_ok_done",   done_cnt, 32'd1);
    check("csum_ok_error",  {31'h0, load_error},  32'h0);
    check("csum_ok_active", {31'h0, load_active}, 32'h0);

    // Bad checksum
    clear_log();
    send_word(32'd1);
    send_word(32'h0102_0304);
    send_byte(8'h05, 1'b1);
    idle_bits(2);
    check("csum_bad_done",   done_cnt, 32'd0);
    check("csum_bad_error",  {31'h0, load_error},  32'h1);
    check("csum_bad_active", {31'h0, load_active}, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
